dmem_responder: RTL and testbench

//   Data-memory slave answering the core's LD/ST port (mem_in_s / mem_out_s plus 32-bit address).

---
 rtl/dmem_responder_pkg.sv | 36 +++
 rtl/dmem_lfsr.sv | 21 ++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states and the core LD/ST port structs.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    D_IDLE,
    D_BUSY,
    D_RESP
  } dmem_state_e;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  // Wide enough for latency_p + 3 extra random cycles at latency_p = 15.
  localparam int unsigned CNT_W = 5;

  function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                             input logic [7:0]  b,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    r[8*lane +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/dmem_lfsr.sv
// 4-bit maximal LFSR (x^4+x^3+1) stepping once per enable; used for random response latency.
module dmem_lfsr
  #(parameter logic [3:0] seed_p = 4'h9)
  (input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   output logic [3:0] lfsr_o);

  logic [3:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    if (!reset) lfsr_d = seed_p;
  end

  always_ff @(posedge clk) lfsr_q <= lfsr_d;

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the core LD/ST port: one request at a time, word/byte access, fixed latency.
// Define DMEM_RAND_LAT_EN to add 0..3 LFSR-chosen extra cycles per request.
//   state  | meaning
//   D_IDLE | waiting; request accepted (resp_o.yumi) when req_i.valid
//   D_BUSY | latency counter running; array access on exit
//   D_RESP | resp_o.valid held with stable data until req_i.yumi
module dmem_responder
  import dmem_responder_pkg::*;
  #(parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 2,
    parameter logic [3:0]  lfsr_seed_p  = 4'h9)
  (input  logic        clk,
   input  logic        reset,
   input  mem_in_s     req_i,
   input  logic [31:0] addr_i,
   output mem_out_s    resp_o,
   output logic        busy_o,
   output logic [15:0] txn_count_o);

  localparam int unsigned AW = addr_width_p;

  logic [31:0] mem [2**addr_width_p];

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic             wen_q, wen_d;
  logic             bnw_q, bnw_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic [15:0]      txn_q, txn_d;

  logic             accept;
  logic [1:0]       extra;
  logic [CNT_W-1:0] lat_load;
  logic             access, mem_we;
  logic [AW+1:0]    acc_addr;
  logic             acc_wen, acc_bnw;
  logic [31:0]      acc_wdata;
  logic [AW-1:0]    widx;
  logic [1:0]       lane;
  logic [31:0]      rd_word, wr_word;
  logic             unused_addr;

  assign accept = reset && (state_q == D_IDLE) && req_i.valid;

`ifdef DMEM_RAND_LAT_EN
  logic [3:0] lfsr;
  logic [1:0] unused_lfsr;

  dmem_lfsr #(.seed_p(lfsr_seed_p)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (accept),
    .lfsr_o (lfsr)
  );

  assign extra       = lfsr[1:0];
  assign unused_lfsr = lfsr[3:2];
`else
  logic [3:0] unused_seed;
  assign unused_seed = lfsr_seed_p;
  assign extra       = 2'b00;
`endif

  assign lat_load = CNT_W'(latency_p - 1) + CNT_W'(extra);

  // A latency of one accesses the array straight from the request inputs.
  assign acc_addr  = (state_q == D_IDLE) ? addr_i[AW+1:0]      : addr_q;
  assign acc_wen   = (state_q == D_IDLE) ? req_i.wen           : wen_q;
  assign acc_bnw   = (state_q == D_IDLE) ? req_i.byte_not_word : bnw_q;
  assign acc_wdata = (state_q == D_IDLE) ? req_i.write_data    : wdata_q;
  assign widx      = acc_addr[AW+1:2];
  assign lane      = acc_addr[1:0];
  assign rd_word   = mem[widx];
  assign wr_word   = acc_bnw ? byte_merge(rd_word, acc_wdata[7:0], lane) : acc_wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    bnw_d   = bnw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    txn_d   = txn_q;
    access  = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      D_IDLE: begin
        if (accept) begin
          addr_d  = addr_i[AW+1:0];
          wen_d   = req_i.wen;
          bnw_d   = req_i.byte_not_word;
          wdata_d = req_i.write_data;
          if (lat_load == '0) begin
            state_d = D_RESP;
            access  = 1'b1;
          end else begin
            state_d = D_BUSY;
            cnt_d   = lat_load;
          end
        end
      end
      D_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = D_RESP;
          cnt_d   = '0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      D_RESP: begin
        if (req_i.yumi) begin
          state_d = D_IDLE;
          valid_d = 1'b0;
          rdata_d = '0;
          txn_d   = txn_q + 16'd1;
        end
      end
      default: state_d = D_IDLE;
    endcase

    if (access) begin
      valid_d = 1'b1;
      if (acc_wen)      rdata_d = '0;
      else if (acc_bnw) rdata_d = {24'b0, rd_word[8*lane +: 8]};
      else              rdata_d = rd_word;
    end

    if (!reset) begin
      state_d = D_IDLE;
      cnt_d   = '0;
      rdata_d = '0;
      valid_d = 1'b0;
      txn_d   = '0;
      access  = 1'b0;
    end

    mem_we = access && acc_wen;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    addr_q  <= addr_d;
    wen_q   <= wen_d;
    bnw_q   <= bnw_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
    valid_q <= valid_d;
    txn_q   <= txn_d;
  end

  // Array is deliberately not reset; reset only suppresses a pending write via mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) mem[widx] <= wr_word;
  end

  assign unused_addr      = ^addr_i[31:AW+2];
  assign resp_o.read_data = rdata_q;
  assign resp_o.valid     = valid_q;
  assign resp_o.yumi      = accept;
  assign busy_o           = (state_q != D_IDLE);
  assign txn_count_o      = txn_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (latency_p=2, addr_width_p=10); random-latency run with DMEM_RAND_LAT_EN.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  mem_in_s     req;
  logic [31:0] addr;
  mem_out_s    resp;
  logic        busy;
  logic [15:0] txn;

  int         checks = 0;
  int         errors = 0;
  int         n_txn  = 0;
  logic [3:0] lfsr_m = 4'h9;

  always #5 clk = ~clk;

  dmem_responder #(.addr_width_p(10), .latency_p(LAT), .lfsr_seed_p(4'h9)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .addr_i      (addr),
    .resp_o      (resp),
    .busy_o      (busy),
    .txn_count_o (txn)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat();
`ifdef DMEM_RAND_LAT_EN
    int l;
    l = LAT + int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
    return l;
`else
    return LAT;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    req.valid = 1'b1;
    addr = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_yumi", resp.yumi, 1'b0);
    chk("rst_valid", resp.valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txn", txn, 16'd0);
    req.valid = 1'b0;
    reset = 1'b1;
    lfsr_m = 4'h9;
    n_txn = 0;
  endtask

  task automatic txn_run(input string tag, input logic wen, input logic bnw,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, output int lat);
    int elat;
    @(negedge clk);
    req.valid = 1'b1;
    req.wen = wen;
    req.byte_not_word = bnw;
    req.write_data = wd;
    addr = a;
    #1;
    chk({tag, "_yumi"}, resp.yumi, 1'b1);
    elat = exp_lat();
    lat = 0;
    do begin
      @(negedge clk);
      req.valid = 1'b0;
      lat++;
    end while (!resp.valid && lat < 40);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_rd"}, resp.read_data, exp_rd);
    req.yumi = 1'b1;
    @(negedge clk);
    req.yumi = 1'b0;
    n_txn++;
    chk({tag, "_cnt"}, txn, n_txn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wait_n, elat;
    reset = 1'b0;
    req = '0;
    addr = '0;
    do_reset();

    txn_run("st_word", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, lat);
    txn_run("ld_word", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, lat);

    txn_run("st_aabb", 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 32'h0, lat);
    txn_run("st_byte", 1'b1, 1'b1, 32'h22, 32'hFFFFFF11, 32'h0, lat);
    txn_run("ld_merge", 1'b0, 1'b0, 32'h20, 32'h0, 32'hAA11CCDD, lat);
    txn_run("ld_b3", 1'b0, 1'b1, 32'h23, 32'h0, 32'h000000AA, lat);
    txn_run("ld_b0", 1'b0, 1'b1, 32'h20, 32'h0, 32'h000000DD, lat);

    // held response with valid kept high
    @(negedge clk);
    req.valid = 1'b1;
    req.wen = 1'b0;
    req.byte_not_word = 1'b0;
    addr = 32'h10;
    #1;
    chk("hold_acc_yumi", resp.yumi, 1'b1);
    elat = exp_lat();
    @(negedge clk);
    #1;
    chk("hold_busy", busy, 1'b1);
    chk("hold_busy_yumi", resp.yumi, 1'b0);
    wait_n = 1;
    while (!resp.valid && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    chk("hold_lat", wait_n, elat);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_valid", resp.valid, 1'b1);
      chk("hold_data", resp.read_data, 32'hDEADBEEF);
      chk("hold_yumi", resp.yumi, 1'b0);
      chk("hold_txn", txn, n_txn);
      @(negedge clk);
    end
    req.yumi = 1'b1;
    #1;
    chk("ack_yumi", resp.yumi, 1'b0);
    @(negedge clk);
    req.yumi = 1'b0;
    n_txn++;
    #1;
    chk("b2b_yumi", resp.yumi, 1'b1);
    chk("ack_txn", txn, n_txn);
    req.valid = 1'b0;

    txn_run("st_wrap", 1'b1, 1'b0, 32'h1000, 32'h12345678, 32'h0, lat);
    txn_run("ld_wrap", 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, lat);
    txn_run("st_alias", 1'b1, 1'b0, 32'h1003, 32'hCAFEF00D, 32'h0, lat);
    txn_run("ld_alias", 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, lat);

    // reset while a store is in flight
    txn_run("st_40", 1'b1, 1'b0, 32'h40, 32'h55AA55AA, 32'h0, lat);
    @(negedge clk);
    req.valid = 1'b1;
    req.wen = 1'b1;
    req.byte_not_word = 1'b0;
    req.write_data = 32'h0BADF00D;
    addr = 32'h40;
    @(negedge clk);
    req.valid = 1'b0;
    chk("mid_busy_pre", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1'b0);
    chk("mid_txn", txn, 16'd0);
    chk("mid_valid", resp.valid, 1'b0);
    reset = 1'b1;
    lfsr_m = 4'h9;
    n_txn = 0;
    txn_run("ld_40", 1'b0, 1'b0, 32'h40, 32'h0, 32'h55AA55AA, lat);

`ifdef DMEM_RAND_LAT_EN
    do_reset();
    for (int i = 0; i < 50; i++) begin
      txn_run("rnd_st", 1'b1, 1'b0, 32'h100 + 32'(4*i), 32'h1000 + 32'(i), 32'h0, lat);
      chk("rnd_range_st", 32'(lat >= LAT && lat <= LAT + 3), 32'd1);
      txn_run("rnd_ld", 1'b0, 1'b0, 32'h100 + 32'(4*i), 32'h0, 32'h1000 + 32'(i), lat);
      chk("rnd_range_ld", 32'(lat >= LAT && lat <= LAT + 3), 32'd1);
    end
    chk("rnd_txn100", txn, 16'd100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
